// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM engine: counting modes,
// counter direction and the channel-select width helper.
package pwm_pkg;

  // Counting modes selected by center_align.
  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  // Direction of the period counter in center-aligned mode.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_width(input int channels);
    if (channels <= 2) return 1;
    return $clog2(channels);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, edge/center period counter and the
// shadowed period/mode registers that only change at a period boundary.
// tick marks a counter step; wrap marks that the current step lands on zero,
// so a boundary is tick & wrap.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int BIT_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      center_align,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [BIT_WIDTH-1:0]      period,
  output logic [BIT_WIDTH-1:0]      cnt,
  output logic                      tick,
  output logic                      wrap
);

  logic [PRESCALE_WIDTH-1:0] pcnt;
  logic [PRESCALE_WIDTH-1:0] pcnt_next;
  logic [BIT_WIDTH-1:0]      per_a;
  logic                      mode;
  dir_e                      dir;
  logic [BIT_WIDTH-1:0]      cnt_step;
  dir_e                      dir_step;
  logic                      boundary;

  // Prescaler: tick on pcnt==prescale; a pcnt left above a shrunken
  // prescale simply wraps to zero on the next clk without a tick.
  always_comb begin
    tick      = 1'b0;
    pcnt_next = '0;
    if (enable) begin
      tick = (pcnt == prescale);
      if (pcnt >= prescale) pcnt_next = '0;
      else                  pcnt_next = pcnt + 1'b1;
    end
  end

  // Counter step taken on a tick. Direction is re-derived from where the
  // step lands, so it is always up at zero and down at the top count.
  always_comb begin
    cnt_step = cnt;
    dir_step = DIR_UP;
    if (mode == MODE_EDGE) begin
      cnt_step = (cnt >= per_a) ? '0 : cnt + 1'b1;
      dir_step = DIR_UP;
    end else if (per_a == '0) begin
      cnt_step = '0;
      dir_step = DIR_UP;
    end else begin
      if (dir == DIR_UP && cnt < per_a) cnt_step = cnt + 1'b1;
      else if (cnt != '0)               cnt_step = cnt - 1'b1;
      else                              cnt_step = cnt + 1'b1;
      if (cnt_step == '0)         dir_step = DIR_UP;
      else if (cnt_step >= per_a) dir_step = DIR_DOWN;
      else if (cnt_step > cnt)    dir_step = DIR_UP;
      else                        dir_step = DIR_DOWN;
    end
    wrap     = (cnt_step == '0);
    boundary = tick & wrap;
  end

  // Timebase state; while disabled everything parks at the start of a
  // period and keeps tracking the live period/mode settings.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt  <= '0;
      cnt   <= '0;
      dir   <= DIR_UP;
      per_a <= '0;
      mode  <= MODE_EDGE;
    end else if (!enable) begin
      pcnt  <= '0;
      cnt   <= '0;
      dir   <= DIR_UP;
      per_a <= period;
      mode  <= center_align;
    end else begin
      pcnt <= pcnt_next;
      if (tick) begin
        cnt <= cnt_step;
        dir <= dir_step;
      end
      if (boundary) begin
        per_a <= period;
        mode  <= center_align;
      end
    end
  end

endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM engine: one shared timebase, double-buffered duty per
// channel, per-channel polarity and registered outputs.
// Handshake: duty_wr_en is a single-cycle strobe with no back-pressure; every
// clk it is high writes duty_wr_data into the shadow of channel duty_wr_sel
// (indices >= CHANNELS are dropped).
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int  CHANNELS       = 4,
  parameter int  BIT_WIDTH      = 8,
  parameter int  PRESCALE_WIDTH = 8,
  localparam int SEL_W          = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      center_align,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [BIT_WIDTH-1:0]      period,
  input  logic                      duty_wr_en,
  input  logic [SEL_W-1:0]          duty_wr_sel,
  input  logic [BIT_WIDTH:0]        duty_wr_data,
  input  logic [CHANNELS-1:0]       polarity,
  output logic [CHANNELS-1:0]       out,
  output logic                      period_start
);

  logic [BIT_WIDTH-1:0] cnt;
  logic                 tick;
  logic                 wrap;
  logic                 boundary;
  logic                 load;
  logic                 fresh;
  logic [BIT_WIDTH:0]   shadow [CHANNELS];
  logic [BIT_WIDTH:0]   duty_a [CHANNELS];
  logic [CHANNELS-1:0]  raw;
  logic [CHANNELS-1:0]  out_d;

  pwm_timebase #(
    .BIT_WIDTH      (BIT_WIDTH),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .center_align (center_align),
    .prescale     (prescale),
    .period       (period),
    .cnt          (cnt),
    .tick         (tick),
    .wrap         (wrap)
  );

  assign boundary = tick & wrap;
  // Active duties follow the shadows continuously while idle, and only at a
  // boundary while running, so a waveform never changes mid-period.
  assign load = ~enable | boundary;

  // Duty shadow/active registers; a write coinciding with a load lands in
  // the shadow only, the active copy takes the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        duty_a[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load) duty_a[i] <= shadow[i];
        if (duty_wr_en && (duty_wr_sel == SEL_W'(i))) shadow[i] <= duty_wr_data;
      end
    end
  end

  // Per-channel compare and polarity; idle level is the polarity bit.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign raw[i]   = ({1'b0, cnt} < duty_a[i]);
    assign out_d[i] = enable ? (raw[i] ^ polarity[i]) : polarity[i];
  end

  // fresh is high in the first clk in which cnt sits at zero for a new
  // period (after a boundary, or the first clk after enable rises).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fresh <= 1'b1;
    else if (!enable) fresh <= 1'b1;
    else              fresh <= boundary;
  end

  // Output flops; period_start goes through the same single register stage
  // as out, so it is high while out shows the first count of a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= out_d;
      period_start <= enable & fresh;
    end
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: a period-phase reference model predicts each
// registered output word, a monitor compares it against the DUT.
module tb_pwm_multichannel;

  localparam int CHANNELS       = 4;
  localparam int BIT_WIDTH      = 8;
  localparam int PRESCALE_WIDTH = 8;
  localparam int SEL_W          = 2;
  localparam int OW             = CHANNELS + 1;

  // ---------------- clock / reset ----------------
  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic                      enable = 1'b0;
  logic                      center_align = 1'b0;
  logic [PRESCALE_WIDTH-1:0] prescale = '0;
  logic [BIT_WIDTH-1:0]      period = '0;
  logic                      duty_wr_en = 1'b0;
  logic [SEL_W-1:0]          duty_wr_sel = '0;
  logic [BIT_WIDTH:0]        duty_wr_data = '0;
  logic [CHANNELS-1:0]       polarity = '0;
  logic [CHANNELS-1:0]       out;
  logic                      period_start;

  always #5 clk = ~clk;

  pwm_multichannel #(
    .CHANNELS       (CHANNELS),
    .BIT_WIDTH      (BIT_WIDTH),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .center_align (center_align),
    .prescale     (prescale),
    .period       (period),
    .duty_wr_en   (duty_wr_en),
    .duty_wr_sel  (duty_wr_sel),
    .duty_wr_data (duty_wr_data),
    .polarity     (polarity),
    .out          (out),
    .period_start (period_start)
  );

  // ---------------- reference model ----------------
  // Position is kept as "tick index k within the current period"; the count
  // is derived from k, the period length from the period/mode rules.
  logic [OW-1:0] exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  m_pcnt = 0;
  int  m_k = 0;
  int  m_per = 0;
  bit  m_mode = 0;
  bit  m_fresh = 1;
  int  m_duty[CHANNELS];
  int  m_shadow[CHANNELS];

  function automatic int period_len(int per, bit mode);
    if (mode) return (per == 0) ? 1 : 2 * per;
    return per + 1;
  endfunction

  function automatic int cnt_at(int k, int per, bit mode);
    if (!mode) return k;
    return (k <= per) ? k : 2 * per - k;
  endfunction

  // True when the coming posedge ends the current period.
  function automatic bit will_boundary();
    return enable && (m_pcnt == int'(prescale)) &&
           (m_k + 1 == period_len(m_per, m_mode));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pcnt = 0; m_k = 0; m_per = 0; m_mode = 0; m_fresh = 1;
      for (int i = 0; i < CHANNELS; i++) begin
        m_duty[i] = 0;
        m_shadow[i] = 0;
      end
      exp_q.delete();
    end else begin
      int c;
      logic [OW-1:0] e;
      c = cnt_at(m_k, m_per, m_mode);
      for (int i = 0; i < CHANNELS; i++)
        e[i] = enable ? ((c < m_duty[i]) ^ polarity[i]) : polarity[i];
      e[CHANNELS] = enable & m_fresh;
      exp_q.push_back(e);
      if (!enable) begin
        m_pcnt = 0; m_k = 0; m_fresh = 1;
        m_per = int'(period); m_mode = center_align;
        for (int i = 0; i < CHANNELS; i++) m_duty[i] = m_shadow[i];
      end else begin
        bit t;
        m_fresh = 0;
        t = (m_pcnt == int'(prescale));
        m_pcnt = (m_pcnt >= int'(prescale)) ? 0 : m_pcnt + 1;
        if (t) begin
          m_k = m_k + 1;
          if (m_k >= period_len(m_per, m_mode)) begin
            m_k = 0;
            m_fresh = 1;
            for (int i = 0; i < CHANNELS; i++) m_duty[i] = m_shadow[i];
            m_per = int'(period);
            m_mode = center_align;
          end
        end
      end
      if (duty_wr_en && int'(duty_wr_sel) < CHANNELS)
        m_shadow[duty_wr_sel] = int'(duty_wr_data);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [OW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tests++;
        if (out !== '0 || period_start !== 1'b0 || dut.u_timebase.cnt !== '0) begin
          fails++;
          $display("FAIL reset_state t=%0t out=%b period_start=%b cnt=%0d, required out=0 period_start=0 cnt=0",
                   $time, out, period_start, dut.u_timebase.cnt);
        end
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if ({period_start, out} !== e) begin
          fails++;
          $display("FAIL cycle_output t=%0t period_start=%b out=%b, required period_start=%b out=%b",
                   $time, period_start, out, e[CHANNELS], e[CHANNELS-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_duty(input int ch, input int val);
    duty_wr_en   = 1'b1;
    duty_wr_sel  = SEL_W'(ch);
    duty_wr_data = (BIT_WIDTH + 1)'(val);
    @(negedge clk);
    duty_wr_en   = 1'b0;
  endtask

  task automatic wait_boundary();
    for (int w = 0; w < 1000; w++) begin
      if (will_boundary()) break;
      @(negedge clk);
    end
  endtask

  task automatic random_duty_write();
    int v;
    v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 17)) : int'($urandom_range(0, 511));
    write_duty(int'($urandom_range(0, CHANNELS - 1)), v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;

    // Edge mode, period 9: duty 3, 0, 10 (above period) and 511.
    period = 8'd9;
    write_duty(0, 3);
    write_duty(1, 0);
    write_duty(2, 10);
    write_duty(3, 511);
    enable = 1'b1;
    run(40);

    // Center mode, period 4, duty 2 (switch lands at a boundary).
    center_align = 1'b1;
    period = 8'd4;
    write_duty(0, 2);
    run(40);

    // Prescaled edge mode.
    center_align = 1'b0;
    period = 8'd9;
    prescale = 8'd3;
    run(100);

    // Mid-period duty change, then a write exactly on the boundary clk.
    prescale = 8'd0;
    run(14);
    write_duty(0, 7);
    run(25);
    wait_boundary();
    write_duty(0, 3);
    run(30);

    // Inverted channel, enable drop, then asynchronous reset mid-run.
    polarity = 4'b0010;
    write_duty(1, 3);
    run(25);
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    run(15);
    @(posedge clk);
    #2 rst_n = 1'b0;
    enable = 1'b0;
    run(2);
    rst_n = 1'b1;
    write_duty(0, 4);
    write_duty(1, 3);
    enable = 1'b1;
    run(25);

    // Randomized settings, writes and prescale changes.
    for (int s = 0; s < 60; s++) begin
      int n;
      prescale     = PRESCALE_WIDTH'($urandom_range(0, 3));
      period       = BIT_WIDTH'($urandom_range(1, 15));
      center_align = 1'($urandom_range(0, 1));
      polarity     = CHANNELS'($urandom_range(0, 15));
      enable       = ($urandom_range(0, 9) != 0);
      n = int'($urandom_range(20, 80));
      for (int c = 0; c < n; c++) begin
        if ($urandom_range(0, 7) == 0) random_duty_write();
        else @(negedge clk);
      end
    end

    run(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
